stage5wb_q: RTL and testbench

- Parametrised successor to the write-back stage.
- Decouples the last pipeline stage from the register-file write port through a DEPTH-entry in-order retire queue with a valid/ready handshake.
- Retires the register, link-register and flag writes of each instruction together, in program order.
- Provides a forwarding lookup into pending (not yet retired) register writes. Sits between the RA/execute result path and the register file, LR and flag register.

---
 rtl/stage5wb_q_pkg.sv | 59 +++++
 rtl/stage5wb_q_retire_fifo.sv | 68 ++++++
 rtl/stage5wb_q.sv | 135 +++++++++++++
 tb/tb_stage5wb_q.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage5wb_q_pkg.sv
// Shared opcode definitions and retire-entry layout for the write-back retire queue.
package stage5wb_q_pkg;

  localparam int unsigned OPC_W = 8;

  // Opcode class lives in the top two opcode bits.
  typedef enum logic [1:0] {
    OCLS_ALU  = 2'b00,
    OCLS_LOAD = 2'b01,
    OCLS_CTRL = 2'b10,
    OCLS_SYS  = 2'b11
  } opc_class_e;

  localparam logic [OPC_W-1:0] OPC_NOP     = 8'h00;
  localparam logic [OPC_W-1:0] OPC_S_SRMOV = 8'hC4;

  // ALU and load classes write the register file; NOP, control and system ops do not.
  function automatic logic reg_write_fn(input logic [OPC_W-1:0] opc);
    opc_class_e cls;
    cls = opc_class_e'(opc[OPC_W-1 -: 2]);
    return ((cls == OCLS_ALU) || (cls == OCLS_LOAD)) && (opc != OPC_NOP);
  endfunction

  // Entry layout, LSB upwards: lw, rw, waddr, flags, result, instr, pc.
  localparam int unsigned ENT_OFF_LW    = 0;
  localparam int unsigned ENT_OFF_RW    = 1;
  localparam int unsigned ENT_OFF_WADDR = 2;

  function automatic int unsigned ent_off_flags(input int unsigned raddr_w);
    return ENT_OFF_WADDR + raddr_w;
  endfunction

  function automatic int unsigned ent_off_result(input int unsigned raddr_w,
                                                 input int unsigned flag_w);
    return ent_off_flags(raddr_w) + flag_w;
  endfunction

  function automatic int unsigned ent_off_instr(input int unsigned raddr_w,
                                                input int unsigned flag_w,
                                                input int unsigned data_w);
    return ent_off_result(raddr_w, flag_w) + data_w;
  endfunction

  function automatic int unsigned ent_off_pc(input int unsigned raddr_w,
                                             input int unsigned flag_w,
                                             input int unsigned data_w,
                                             input int unsigned instr_w);
    return ent_off_instr(raddr_w, flag_w, data_w) + instr_w;
  endfunction

  function automatic int unsigned ent_width(input int unsigned raddr_w,
                                            input int unsigned flag_w,
                                            input int unsigned data_w,
                                            input int unsigned instr_w,
                                            input int unsigned pc_w);
    return ent_off_pc(raddr_w, flag_w, data_w, instr_w) + pc_w;
  endfunction

endpackage

// File: rtl/stage5wb_q_retire_fifo.sv
// Generic DEPTH x W circular buffer; exposes all entries in age order (index 0 = head).
module wb_retire_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH*W-1:0]       entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state, cleared asynchronously; pending entries are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; no reset needed since validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Rotate storage so consumers see entries oldest-first with a thermometer valid mask.
  always_comb begin
    entries_o = '0;
    valid_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_o[i*W +: W] = mem_q[rd_ptr_q + PTR_W'(i)];
      valid_o[i]          = (CNT_W'(i) < count_q);
    end
  end

endmodule

// File: rtl/stage5wb_q.sv
// Write-back retire queue: in-order atomic retire of reg/LR/flag writes plus forwarding lookup.
module stage5wb_q
  import stage5wb_q_pkg::*;
#(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned INSTR_W = 24,
  parameter int unsigned PC_W    = 24,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [FLAG_W-1:0]  flags_in,
  input  logic [RADDR_W-1:0] reg_waddr_in,
  input  logic               rf_gnt,
  output logic [RADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_we,
  output logic [DATA_W-1:0]  lr_wdata,
  output logic               lr_we,
  output logic [FLAG_W-1:0]  flag_wdata,
  output logic               flag_we,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               retire,
  input  logic [RADDR_W-1:0] fwd_raddr,
  output logic               fwd_hit,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               empty,
  output logic [31:0]        retired_cnt
);

  localparam int unsigned OFF_FLAGS  = ent_off_flags(RADDR_W);
  localparam int unsigned OFF_RESULT = ent_off_result(RADDR_W, FLAG_W);
  localparam int unsigned OFF_INSTR  = ent_off_instr(RADDR_W, FLAG_W, DATA_W);
  localparam int unsigned OFF_PC     = ent_off_pc(RADDR_W, FLAG_W, DATA_W, INSTR_W);
  localparam int unsigned ENT_W      = ent_width(RADDR_W, FLAG_W, DATA_W, INSTR_W, PC_W);

  logic [OPC_W-1:0]            opcode;
  logic [ENT_W-1:0]            ent_in;
  logic [ENT_W-1:0]            head;
  logic [DEPTH*ENT_W-1:0]      entries;
  logic [DEPTH-1:0]            valid;
  logic                        full;
  logic                        fifo_empty;
  logic [$clog2(DEPTH):0]      unused_fifo_count;
  logic                        unused_entry_bits;
  logic                        accept;
  logic                        h_valid, h_rw, h_lw;
  logic [31:0]                 retired_cnt_q, retired_cnt_d;

  assign opcode   = instr_in[INSTR_W-1 -: OPC_W];
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign empty    = fifo_empty;
  assign ent_in   = {pc_in, instr_in, result_in, flags_in, reg_waddr_in,
                     reg_write_fn(opcode), (opcode == OPC_S_SRMOV)};

  // Only rw/waddr/result of non-head entries feed the forwarding search.
  assign unused_entry_bits = ^entries;

  wb_retire_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (accept),
    .pop_i     (retire),
    .wdata_i   (ent_in),
    .full_o    (full),
    .empty_o   (fifo_empty),
    .count_o   (unused_fifo_count),
    .entries_o (entries),
    .valid_o   (valid)
  );

  // Head decode and retire: LR and flag writes stall with a blocked register write to stay atomic.
  always_comb begin
    head    = entries[ENT_W-1:0];
    h_valid = valid[0];
    h_rw    = head[ENT_OFF_RW];
    h_lw    = head[ENT_OFF_LW];
    retire  = h_valid && (!h_rw || rf_gnt);
    reg_we  = retire && h_rw;
    lr_we   = retire && h_lw;
    flag_we = retire;
    reg_waddr  = '0;
    reg_wdata  = '0;
    lr_wdata   = '0;
    flag_wdata = '0;
    pc_out     = '0;
    instr_out  = '0;
    if (h_valid) begin
      reg_waddr  = head[ENT_OFF_WADDR +: RADDR_W];
      reg_wdata  = head[OFF_RESULT +: DATA_W];
      lr_wdata   = head[OFF_RESULT +: DATA_W];
      flag_wdata = head[OFF_FLAGS +: FLAG_W];
      pc_out     = head[OFF_PC +: PC_W];
      instr_out  = head[OFF_INSTR +: INSTR_W];
    end
  end

  // Forwarding: scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i*ENT_W + ENT_OFF_RW] &&
          (entries[i*ENT_W + ENT_OFF_WADDR +: RADDR_W] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[i*ENT_W + OFF_RESULT +: DATA_W];
      end
    end
  end

  assign retired_cnt_d = retired_cnt_q + 32'd1;
  assign retired_cnt   = retired_cnt_q;

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt_q <= '0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

endmodule

// File: tb/tb_stage5wb_q.sv
// Randomised + directed bench for stage5wb_q against a queue-based reference model.
module tb_stage5wb_q;

  localparam int unsigned DW = 24, IW = 24, PW = 24, AW = 4, FW = 4, DEPTH = 4;
  localparam logic [7:0] OP_ADD = 8'h05, OP_LD = 8'h41, OP_ST = 8'h90, OP_SRMOV = 8'hC4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [PW-1:0] pc_in;
  logic [IW-1:0] instr_in;
  logic [DW-1:0] result_in;
  logic [FW-1:0] flags_in;
  logic [AW-1:0] reg_waddr_in;
  logic          rf_gnt;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata, lr_wdata, fwd_data;
  logic          reg_we, lr_we, flag_we, retire, fwd_hit, empty;
  logic [FW-1:0] flag_wdata;
  logic [PW-1:0] pc_out;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] fwd_raddr;
  logic [31:0]   retired_cnt;

  stage5wb_q #(
    .DATA_W(DW), .INSTR_W(IW), .PC_W(PW), .RADDR_W(AW), .FLAG_W(FW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .result_in(result_in), .flags_in(flags_in),
    .reg_waddr_in(reg_waddr_in), .rf_gnt(rf_gnt),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .lr_wdata(lr_wdata), .lr_we(lr_we), .flag_wdata(flag_wdata), .flag_we(flag_we),
    .pc_out(pc_out), .instr_out(instr_out), .retire(retire),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .empty(empty), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
    logic [DW-1:0] result;
    logic [FW-1:0] flags;
    logic [AW-1:0] waddr;
    bit            rw;
    bit            lw;
  } ent_t;

  ent_t          q[$];
  logic [31:0]   m_cnt = '0;
  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural rules: ALU/load classes except NOP write a register; SRMOV writes LR.
  function automatic bit m_rw(input logic [7:0] op);
    return (op != 8'h00) && (op < 8'h80);
  endfunction

  function automatic bit m_lw(input logic [7:0] op);
    return op == OP_SRMOV;
  endfunction

  task automatic check_outputs();
    ent_t          h;
    bit            hv, ret, hit;
    logic [DW-1:0] fd;
    hv = (q.size() > 0);
    h  = '{default: '0};
    if (hv) h = q[0];
    ret = hv && (!h.rw || rf_gnt);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("empty", empty, !hv);
    chk("retire", retire, ret);
    chk("reg_we", reg_we, ret && h.rw);
    chk("lr_we", lr_we, ret && h.lw);
    chk("flag_we", flag_we, ret);
    chk("reg_waddr", reg_waddr, h.waddr);
    chk("reg_wdata", reg_wdata, h.result);
    chk("lr_wdata", lr_wdata, h.result);
    chk("flag_wdata", flag_wdata, h.flags);
    chk("pc_out", pc_out, h.pc);
    chk("instr_out", instr_out, h.instr);
    hit = 0;
    fd  = '0;
    foreach (q[i]) begin
      if (q[i].rw && (q[i].waddr == fwd_raddr)) begin
        hit = 1;
        fd  = q[i].result;
      end
    end
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, fd);
    chk("retired_cnt", retired_cnt, m_cnt);
  endtask

  // Called just after a negedge with inputs driven; checks, then advances the model across posedge.
  task automatic step();
    bit   acc, ret;
    ent_t e;
    #1;
    check_outputs();
    acc      = in_valid && (q.size() < DEPTH);
    ret      = (q.size() > 0) && (!q[0].rw || rf_gnt);
    e.pc     = pc_in;
    e.instr  = instr_in;
    e.result = result_in;
    e.flags  = flags_in;
    e.waddr  = reg_waddr_in;
    e.rw     = m_rw(instr_in[IW-1 -: 8]);
    e.lw     = m_lw(instr_in[IW-1 -: 8]);
    @(posedge clk);
    if (ret) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [7:0] op, input logic [AW-1:0] wa,
                       input logic [DW-1:0] res, input logic [FW-1:0] fl,
                       input bit gnt, input logic [AW-1:0] fa);
    in_valid     = v;
    pc_in        = PW'($urandom);
    instr_in     = {op, 16'($urandom)};
    result_in    = res;
    flags_in     = fl;
    reg_waddr_in = wa;
    rf_gnt       = gnt;
    fwd_raddr    = fa;
  endtask

  task automatic idle(input bit gnt, input int unsigned n);
    for (int unsigned c = 0; c < n; c++) begin
      drive(0, OP_ADD, '0, '0, '0, gnt, 4'd0);
      step();
    end
  endtask

  initial begin
    int unsigned k;
    int unsigned retire_cyc, acc5_cyc;
    rst = 1'b0;
    drive(0, OP_ADD, '0, '0, '0, 0, '0);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single write
    drive(1, OP_ADD, 4'd3, 24'h00ABCD, 4'h5, 1, 4'd3);
    step();
    drive(0, OP_ADD, '0, '0, '0, 1, 4'd3);
    #1;
    chk("single_reg_we", reg_we, 1);
    chk("single_wdata", reg_wdata, 24'h00ABCD);
    chk("single_flag", flag_wdata, 4'h5);
    step();
    #1;
    chk("single_cnt", retired_cnt, 32'd1);

    // Fill/stall then drain; 5th entry enters one cycle after the first retire
    k = 0; retire_cyc = 0; acc5_cyc = 0;
    for (int unsigned c = 0; c < 20 && k < 5; c++) begin
      drive(1, OP_ADD, AW'(k + 1), DW'(32'h100 + k), FW'(k), k >= 4, 4'd1);
      #1;
      if (k == 4 && retire_cyc == 0 && retire) retire_cyc = c;
      if (k == 4 && in_ready) acc5_cyc = c;
      if (q.size() < DEPTH) k++;
      step();
    end
    chk("fill_5th_accept", acc5_cyc, retire_cyc + 1);
    idle(1, 6);

    // SRMOV retires with the grant held low since it has no register write
    drive(1, OP_SRMOV, 4'd6, 24'h123456, 4'hA, 0, 4'd6);
    step();
    drive(0, OP_ADD, '0, '0, '0, 0, 4'd6);
    #1;
    chk("srmov_lr_we", lr_we, 1);
    chk("srmov_lr_data", lr_wdata, 24'h123456);
    chk("srmov_reg_we", reg_we, 0);
    step();

    // Forwarding: youngest match wins
    drive(1, OP_ADD, 4'd2, 24'h11, 4'h1, 0, 4'd2); step();
    drive(1, OP_LD,  4'd5, 24'h22, 4'h2, 0, 4'd2); step();
    drive(1, OP_ADD, 4'd2, 24'h33, 4'h3, 0, 4'd2); step();
    drive(0, OP_ADD, '0, '0, '0, 0, 4'd2);
    #1;
    chk("fwd_r2_hit", fwd_hit, 1);
    chk("fwd_r2_data", fwd_data, 24'h33);
    step();
    drive(0, OP_ADD, '0, '0, '0, 0, 4'd7);
    #1;
    chk("fwd_r7_hit", fwd_hit, 0);
    chk("fwd_r7_data", fwd_data, 0);
    step();

    // Asynchronous reset with 3 entries pending, asserted between edges
    drive(0, OP_ADD, '0, '0, '0, 1, 4'd2);
    #2;
    rst = 1'b0;
    q.delete();
    m_cnt = '0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_flag_we", flag_we, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_fwd", fwd_hit, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(1, 3);

    // Counter wrap
    drive(1, OP_ST, 4'd1, 24'h777, 4'h7, 1, 4'd1);
    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step();
    idle(1, 1);
    #1;
    chk("cnt_wrap", retired_cnt, 32'd0);
    @(negedge clk);

    // Random traffic
    for (int unsigned c = 0; c < 600; c++) begin
      logic [7:0] op;
      case ($urandom_range(0, 5))
        0: op = OP_ADD;
        1: op = OP_LD;
        2: op = OP_ST;
        3: op = OP_SRMOV;
        4: op = 8'h00;
        default: op = 8'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, op, AW'($urandom_range(0, 7)), DW'($urandom),
            FW'($urandom), $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)));
      step();
    end
    idle(1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
